gcd_job_seq: RTL and testbench
==============================

// Module: gcd_job_seq
// PURPOSE
//  Upstream job sequencer for the GCD core (gcd_ctrl + datapath).
//  - Accepts operand pairs on a valid/ready port and buffers them in a FIFO.
//  - Runs one core job at a time: drives core go/x/y, waits for the core's gld, captures the result.
//  - The core stays in its done state until cleared, so this block pulses core_clr after every job.
//  - Presents each result on a valid/ready output port.
// PARAMETERS
//  W       8     operand/result width
//  DEPTH   4     input FIFO entries (power of 2, >=2)
//  TIMEOUT 1023  maximum cycles in WAIT before aborting the job
// PORTS
//  clk       in   1    clock, rising edge
//  clr       in   1    async reset, ACTIVE-LOW (0 = reset)
//  in_valid  in   1    operand pair valid
//  in_ready  out  1    FIFO not full
//  in_a      in   W    operand A
//  in_b      in   W    operand B
//  res_valid out  1    result valid
//  res_ready in   1    result accepted
//  res_data  out  W    GCD result
//  res_err   out  1    job aborted on timeout
//  busy      out  1    state != IDLE
//  fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
//  core_clr  out  1    core reset, active-high, one-cycle pulse
//  core_go   out  1    core start, one-cycle pulse
//  core_x    out  W    core X operand; held stable for the whole job
//  core_y    out  W    core Y operand; held stable for the whole job
//  core_done in   1    core gld
//  core_gcd  in   W    core GCD register; valid the cycle after core_done rises
// BEHAVIOUR
//  Reset (clr=0), all registered, async:
//   - FIFO empty, state INIT, core_clr=1.
//   - All other outputs 0 (in_ready=0 while in reset).
//  FIFO:
//   - Push when in_valid&&in_ready; in_ready = !full.
//   - Pop only in IDLE when !empty.
//   - Push and pop in the same cycle: fifo_cnt unchanged.
//   - Pointers wrap modulo DEPTH.
//  State machine (one transition per clk):
//   - INIT: core_clr=1 -> IDLE.
//   - IDLE: if !empty, pop the head into core_x/core_y.
//       - a==0 or b==0 -> BYP.
//       - else -> GO.
//   - BYP: res_data = a|b (gcd(a,0)=a, gcd(0,0)=0), res_err=0 -> OUT. Core untouched, no core_go.
//   - GO: core_go=1 for exactly this cycle, timer=0 -> WAIT.
//   - WAIT: timer++ each cycle.
//       - core_done=1 -> CAPT.
//       - else timer==TIMEOUT-1 -> res_data=0, res_err=1 -> REL.
//   - CAPT: res_data<=core_gcd, res_err=0 -> REL.
//   - REL: core_clr=1 for exactly this cycle -> OUT.
//   - OUT: res_valid=1.
//       - res_ready=1 -> res_valid=0 next cycle -> IDLE.
//       - res_data/res_err held until accepted.
//  Latency and ordering:
//   - Min latency push->res_valid: 3 cycles bypass; core path = core cycles + 5.
//   - Results are returned in push order; no overlap between jobs.
//  Boundary cases:
//   - core_done already high in GO is ignored; only WAIT samples core_done.
//   - res_ready while !res_valid is ignored.
//   - Reset mid-job drops the job and the FIFO contents. core_clr is asserted through INIT.
// TESTING
//  1. Push (48,18); core model behaves -> one core_go pulse, core_x=48, core_y=18 stable; res_data=6, res_err=0; one core_clr pulse.
//  2. Push (0,7) then (0,0) -> res_data=7 then 0; core_go never asserted; 3-cycle latency each.
//  3. DEPTH=4, job busy, push 5 pairs back-to-back -> in_ready=0 on 5th until a pop; results in order, fifo_cnt tracks 0..4.
//  4. Result (21,14)->7 with res_ready low 10 cycles -> res_data=7 stable, busy=1, no new core_go until accepted.
//  5. Core model never asserts done -> after TIMEOUT cycles res_err=1, res_data=0, core_clr pulse; next job runs normally.
//  6. Assert clr=0 mid-WAIT with 2 queued -> all outputs reset values, fifo_cnt=0, core_clr=1; resumes cleanly after release.

Source files
------------

// File: rtl/gcd_job_seq.sv
// gcd_job_seq: buffers operand pairs in a FIFO and sequences one GCD core job at a time.
// Latency: push->result 3 cycles on the zero-operand bypass, core cycles + 5 through the core.
// Backpressure: o_in_ready drops while the FIFO is full; a result is held in OUT until i_res_ready.
module gcd_job_seq #(
   parameter int W       = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                     i_clk,
   input  logic                     i_clr,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [W-1:0]             i_in_a,
   input  logic [W-1:0]             i_in_b,
   output logic                     o_res_valid,
   input  logic                     i_res_ready,
   output logic [W-1:0]             o_res_data,
   output logic                     o_res_err,
   output logic                     o_busy,
   output logic [$clog2(DEPTH):0]   o_fifo_cnt,
   output logic                     o_core_clr,
   output logic                     o_core_go,
   output logic [W-1:0]             o_core_x,
   output logic [W-1:0]             o_core_y,
   input  logic                     i_core_done,
   input  logic [W-1:0]             i_core_gcd
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   LP_FULL  = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0] LP_TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_BYP, S_GO, S_WAIT, S_CAPT, S_REL, S_OUT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_mem_a [DEPTH];
   logic [W-1:0]    r_mem_b [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_cnt;
   logic [TW-1:0]   r_timer;
   logic [W-1:0]    r_core_x;
   logic [W-1:0]    r_core_y;
   logic [W-1:0]    r_res_data;
   logic            r_res_err;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_timeout;
   logic            w_head_zero;

   // Input is refused during INIT so nothing lands while the core is still being cleared.
   assign w_full      = (r_cnt == LP_FULL);
   assign w_empty     = (r_cnt == '0);
   assign o_in_ready  = !w_full && (r_state != S_INIT);
   assign w_push      = i_in_valid && o_in_ready;
   assign w_pop       = (r_state == S_IDLE) && !w_empty;
   assign w_timeout   = (r_timer == LP_TLAST);
   assign w_head_zero = (r_mem_a[r_rd_ptr] == '0) || (r_mem_b[r_rd_ptr] == '0);

   assign o_fifo_cnt  = r_cnt;
   assign o_core_x    = r_core_x;
   assign o_core_y    = r_core_y;
   assign o_res_data  = r_res_data;
   assign o_res_err   = r_res_err;

   // FIFO storage: written on every accepted push, no reset needed.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= i_in_a;
         r_mem_b[r_wr_ptr] <= i_in_b;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) r_state <= S_INIT;
      else        r_state <= w_next;
   end

   // Next state plus the per-state strobes decoded straight from the state register.
   always_comb begin
      w_next      = r_state;
      o_core_clr  = 1'b0;
      o_core_go   = 1'b0;
      o_res_valid = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         S_INIT: begin
            o_core_clr = 1'b1;
            o_busy     = 1'b0;
            w_next     = S_IDLE;
         end
         S_IDLE: begin
            o_busy = 1'b0;
            if (!w_empty) w_next = w_head_zero ? S_BYP : S_GO;
         end
         S_BYP:  w_next = S_OUT;
         S_GO: begin
            o_core_go = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            // Only WAIT looks at done, so a done left high from before GO is ignored.
            if (i_core_done)    w_next = S_CAPT;
            else if (w_timeout) w_next = S_REL;
         end
         S_CAPT: w_next = S_REL;
         S_REL: begin
            o_core_clr = 1'b1;
            w_next     = S_OUT;
         end
         S_OUT: begin
            o_res_valid = 1'b1;
            if (i_res_ready) w_next = S_IDLE;
         end
         default: w_next = S_INIT;
      endcase
   end

   // Job datapath: latch operands on pop, run the wait timer, and capture the result.
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) begin
         r_core_x   <= '0;
         r_core_y   <= '0;
         r_timer    <= '0;
         r_res_data <= '0;
         r_res_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_core_x <= r_mem_a[r_rd_ptr];
                  r_core_y <= r_mem_b[r_rd_ptr];
               end
            end
            S_BYP: begin
               // With one operand zero the GCD is the other one; OR covers gcd(0,0)=0 too.
               r_res_data <= r_core_x | r_core_y;
               r_res_err  <= 1'b0;
            end
            S_GO:   r_timer <= '0;
            S_WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (!i_core_done && w_timeout) begin
                  r_res_data <= '0;
                  r_res_err  <= 1'b1;
               end
            end
            S_CAPT: begin
               r_res_data <= i_core_gcd;
               r_res_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_seq.sv
// tb_gcd_job_seq: scoreboard bench for gcd_job_seq with a behavioural GCD core model.
// Latency: expectations are queued on push handshake and checked when a result is accepted.
// Backpressure: exercises full FIFO, stalled result port, core timeout and mid-job reset.
module tb_gcd_job_seq;

   typedef struct packed {
      logic [7:0] d;
      logic       e;
   } exp_t;

   logic       clk = 1'b0;
   logic       i_clr;
   logic       i_in_valid;
   logic       o_in_ready;
   logic [7:0] i_in_a;
   logic [7:0] i_in_b;
   logic       o_res_valid;
   logic       i_res_ready;
   logic [7:0] o_res_data;
   logic       o_res_err;
   logic       o_busy;
   logic [2:0] o_fifo_cnt;
   logic       o_core_clr;
   logic       o_core_go;
   logic [7:0] o_core_x;
   logic [7:0] o_core_y;
   logic       i_core_done;
   logic [7:0] i_core_gcd;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   int         go_pulses  = 0;
   int         clr_pulses = 0;
   int         xy_bad     = 0;
   int         core_delay = 1;
   logic       core_hang  = 1'b0;
   logic       core_act   = 1'b0;
   int         core_cd    = 0;
   logic [7:0] lat_x      = '0;
   logic [7:0] lat_y      = '0;

   gcd_job_seq #(.W(8), .DEPTH(4), .TIMEOUT(1023)) dut (
      .i_clk       (clk),
      .i_clr       (i_clr),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_a      (i_in_a),
      .i_in_b      (i_in_b),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_data  (o_res_data),
      .o_res_err   (o_res_err),
      .o_busy      (o_busy),
      .o_fifo_cnt  (o_fifo_cnt),
      .o_core_clr  (o_core_clr),
      .o_core_go   (o_core_go),
      .o_core_x    (o_core_x),
      .o_core_y    (o_core_y),
      .i_core_done (i_core_done),
      .i_core_gcd  (i_core_gcd)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x = a;
      logic [7:0] y = b;
      logic [7:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait budget expired", name);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_res_valid"}, 32'(o_res_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(o_in_ready),  32'd0);
      chk({tag, "_busy"},      32'(o_busy),      32'd0);
      chk({tag, "_fifo_cnt"},  32'(o_fifo_cnt),  32'd0);
      chk({tag, "_core_clr"},  32'(o_core_clr),  32'd1);
      chk({tag, "_core_go"},   32'(o_core_go),   32'd0);
      chk({tag, "_res_data"},  32'(o_res_data),  32'd0);
      chk({tag, "_res_err"},   32'(o_res_err),   32'd0);
      chk({tag, "_core_xy"},   32'({o_core_x, o_core_y}), 32'd0);
   endtask

   // Offer one pair; the expectation is queued on the handshake edge.
   task automatic push(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ee);
      int t = 0;
      i_in_valid = 1'b1;
      i_in_a     = a;
      i_in_b     = b;
      @(negedge clk);
      while (!o_in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!o_in_ready) begin
         expire("push_ready");
         i_in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(exp_t'{ed, ee});
      #1;
      i_in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (!(i_clr && !o_busy && !o_res_valid && o_fifo_cnt == 0 && sb.size() == 0)
             && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 3000) expire(name);
   endtask

   task automatic cycles_to_valid(output int k);
      k = 0;
      while (!o_res_valid && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   // Behavioural core: latches x/y on go, raises done after core_delay cycles, clears on core_clr.
   initial begin
      i_core_done = 1'b0;
      i_core_gcd  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!i_clr) begin
            i_core_done = 1'b0;
            core_act    = 1'b0;
         end else begin
            if (o_core_clr) begin
               clr_pulses++;
               i_core_done = 1'b0;
               core_act    = 1'b0;
            end
            if (o_core_go) begin
               go_pulses++;
               core_act    = 1'b1;
               lat_x       = o_core_x;
               lat_y       = o_core_y;
               core_cd     = core_delay;
               i_core_done = 1'b0;
            end else if (core_act) begin
               if (o_core_x !== lat_x || o_core_y !== lat_y) xy_bad++;
               if (!core_hang && !i_core_done) begin
                  if (core_cd <= 1) begin
                     i_core_done = 1'b1;
                     i_core_gcd  = gcd8(lat_x, lat_y);
                  end else begin
                     core_cd--;
                  end
               end
            end
         end
      end
   end

   // Monitor: compare every accepted result against the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (i_clr && o_res_valid && i_res_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %0d err %0d with nothing queued",
                     o_res_data, o_res_err);
         end else begin
            mon_e = sb.pop_front();
            chk("res_data", 32'(o_res_data), 32'(mon_e.d));
            chk("res_err",  32'(o_res_err),  32'(mon_e.e));
         end
      end
   end

   initial begin
      int k;
      int go0;
      int clr0;
      int bad;
      i_clr       = 1'b0;
      i_in_valid  = 1'b0;
      i_in_a      = '0;
      i_in_b      = '0;
      i_res_ready = 1'b1;
      #1;
      check_reset("rst");
      repeat (3) @(negedge clk);
      i_clr = 1'b1;
      @(posedge clk);
      #1;

      // 1: plain core job, one go and one clr pulse, core path latency with a 1-cycle core.
      core_delay = 1;
      go0  = go_pulses;
      clr0 = clr_pulses;
      push(8'd48, 8'd18, 8'd6, 1'b0);
      cycles_to_valid(k);
      chk("core_latency", 32'(k), 32'd5);
      wait_idle("idle_t1");
      chk("t1_go_pulses",  32'(go_pulses - go0),   32'd1);
      chk("t1_clr_pulses", 32'(clr_pulses - clr0), 32'd1);
      chk("t1_core_x", 32'(lat_x), 32'd48);
      chk("t1_core_y", 32'(lat_y), 32'd18);

      // 2: zero-operand bypass; res_valid in the third cycle counting the push cycle.
      go0 = go_pulses;
      push(8'd0, 8'd7, 8'd7, 1'b0);
      cycles_to_valid(k);
      chk("byp_latency_0_7", 32'(k), 32'd2);
      wait_idle("idle_t2a");
      push(8'd0, 8'd0, 8'd0, 1'b0);
      cycles_to_valid(k);
      chk("byp_latency_0_0", 32'(k), 32'd2);
      wait_idle("idle_t2b");
      chk("t2_no_go", 32'(go_pulses - go0), 32'd0);

      // 3: fill the FIFO behind a running job; fifth pair waits for a pop.
      core_delay = 30;
      push(8'd40, 8'd24, 8'd8, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_cnt0", 32'(o_fifo_cnt), 32'd0);
      push(8'd12, 8'd8, 8'd4, 1'b0);
      chk("t3_cnt1", 32'(o_fifo_cnt), 32'd1);
      push(8'd9, 8'd6, 8'd3, 1'b0);
      chk("t3_cnt2", 32'(o_fifo_cnt), 32'd2);
      push(8'd35, 8'd21, 8'd7, 1'b0);
      chk("t3_cnt3", 32'(o_fifo_cnt), 32'd3);
      push(8'd17, 8'd5, 8'd1, 1'b0);
      chk("t3_cnt4", 32'(o_fifo_cnt), 32'd4);
      chk("t3_full_ready", 32'(o_in_ready), 32'd0);
      push(8'd100, 8'd75, 8'd25, 1'b0);
      chk("t3_cnt_after_pop", 32'(o_fifo_cnt), 32'd4);
      wait_idle("idle_t3");

      // 4: result port stalled for 10 cycles with a second job queued.
      core_delay  = 3;
      i_res_ready = 1'b0;
      push(8'd21, 8'd14, 8'd7, 1'b0);
      push(8'd6, 8'd4, 8'd2, 1'b0);
      cycles_to_valid(k);
      if (!o_res_valid) expire("t4_valid");
      go0 = go_pulses;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (o_res_data !== 8'd7 || o_res_err !== 1'b0 || !o_res_valid || !o_busy) bad++;
      end
      chk("t4_stall_hold", 32'(bad), 32'd0);
      chk("t4_no_new_go",  32'(go_pulses - go0), 32'd0);
      i_res_ready = 1'b1;
      wait_idle("idle_t4");

      // 5: core never finishes -> timeout result, then a normal job.
      core_hang = 1'b1;
      clr0 = clr_pulses;
      push(8'd30, 8'd12, 8'd0, 1'b1);
      k = 0;
      while (!o_core_go && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!o_core_go) expire("t5_go");
      cycles_to_valid(k);
      chk("t5_timeout_cycles", 32'(k), 32'd1025);
      wait_idle("idle_t5");
      chk("t5_clr_pulses", 32'(clr_pulses - clr0), 32'd1);
      core_hang = 1'b0;
      push(8'd15, 8'd10, 8'd5, 1'b0);
      wait_idle("idle_t5b");

      // 6: reset in the middle of WAIT with two pairs queued.
      core_hang = 1'b1;
      push(8'd50, 8'd20, 8'd10, 1'b0);
      push(8'd8, 8'd4, 8'd4, 1'b0);
      push(8'd9, 8'd3, 8'd3, 1'b0);
      chk("t6_cnt_push_pop", 32'(o_fifo_cnt), 32'd2);
      repeat (5) @(posedge clk);
      #3;
      i_clr = 1'b0;
      sb.delete();
      #1;
      check_reset("midrst");
      core_hang = 1'b0;
      repeat (3) @(negedge clk);
      i_clr = 1'b1;
      #1;
      chk("t6_init_core_clr", 32'(o_core_clr), 32'd1);
      chk("t6_init_in_ready", 32'(o_in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("t6_idle_in_ready", 32'(o_in_ready), 32'd1);
      chk("t6_idle_core_clr", 32'(o_core_clr), 32'd0);
      go0 = go_pulses;
      push(8'd27, 8'd18, 8'd9, 1'b0);
      push(8'd5, 8'd0, 8'd5, 1'b0);
      wait_idle("idle_t6");
      chk("t6_go_pulses", 32'(go_pulses - go0), 32'd1);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("core_xy_stable",   32'(xy_bad),    32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
